// File: rtl/rv32_alu_datapath_if.sv
// Instruction/debug bus between the fetch side and the RV32I ALU datapath.
// The fetch side (master) drives instr and dbg_addr. The datapath (slave) returns decode/result/status.
interface rv32_alu_datapath_if;
  logic [31:0] instr;
  logic [31:0] result;
  logic        ebreak;
  logic        illegal;
  logic        halted;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output instr,
    output dbg_addr,
    input  result,
    input  ebreak,
    input  illegal,
    input  halted,
    input  dbg_data
  );

  modport slave (
    input  instr,
    input  dbg_addr,
    output result,
    output ebreak,
    output illegal,
    output halted,
    output dbg_data
  );
endinterface

// File: rtl/rv32_alu_datapath.sv
// Single-cycle RV32I OP/OP-IMM execution datapath with a 32x32 register file and EBREAK halt.
// Decode, operand read and ALU are combinational. Write-back and halt commit on the rising edge.
module rv32_alu_datapath (
  input logic                clk,
  input logic                reset,
  rv32_alu_datapath_if.slave bus
);

  localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OPC_OP       = 7'b0110011;
  localparam logic [6:0]  F7_BASE      = 7'b0000000;
  localparam logic [6:0]  F7_ALT       = 7'b0100000;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [6:0]  funct7;
  logic [31:0] imm_i;

  assign opcode  = bus.instr[6:0];
  assign rd_idx  = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];
  assign imm_i   = {{20{bus.instr[31]}}, bus.instr[31:20]};

  // Architectural state
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        halted_q;
  logic        halted_d;

  // Decode
  alu_op_e alu_op;
  logic    alu_valid;
  logic    use_imm;
  logic    is_ebreak;

  assign is_ebreak = (bus.instr == INSTR_EBREAK);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path through the
    // case statements leaves a signal unassigned. Otherwise a latch would be inferred.
    alu_op    = ALU_ADD;
    alu_valid = 1'b0;
    use_imm   = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        unique case (funct3)
          3'b000: begin alu_op = ALU_ADD;  alu_valid = 1'b1; end
          3'b010: begin alu_op = ALU_SLT;  alu_valid = 1'b1; end
          3'b011: begin alu_op = ALU_SLTU; alu_valid = 1'b1; end
          3'b100: begin alu_op = ALU_XOR;  alu_valid = 1'b1; end
          3'b110: begin alu_op = ALU_OR;   alu_valid = 1'b1; end
          3'b111: begin alu_op = ALU_AND;  alu_valid = 1'b1; end
          3'b001: begin
            alu_op    = ALU_SLL;
            alu_valid = (funct7 == F7_BASE);
          end
          3'b101: begin
            alu_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            alu_valid = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_valid = 1'b1;
          unique case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          // Only SUB and SRA exist in the alternate funct7 space
          if (funct3 == 3'b000) begin
            alu_op    = ALU_SUB;
            alu_valid = 1'b1;
          end else if (funct3 == 3'b101) begin
            alu_op    = ALU_SRA;
            alu_valid = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Operand read; x0 is forced to zero on every read port
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;

  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : regs_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : regs_q[rs2_idx];
  assign op_a    = rs1_val;
  assign op_b    = use_imm ? imm_i : rs2_val;
  assign shamt   = op_b[4:0];

  // ALU
  logic [31:0] alu_out;

  always_comb begin
    alu_out = 32'd0;
    unique case (alu_op)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLL:  alu_out = op_a << shamt;
      ALU_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_out = {31'd0, op_a < op_b};
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SRL:  alu_out = op_a >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_out = op_a | op_b;
      ALU_AND:  alu_out = op_a & op_b;
      default:  alu_out = 32'd0;
    endcase
  end

  assign bus.result   = alu_valid ? alu_out : 32'd0;
  assign bus.ebreak   = is_ebreak;
  assign bus.illegal  = !alu_valid && !is_ebreak;
  assign bus.halted   = halted_q;
  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];

  // Next state; reset priority is applied in the flop block
  logic wr_en;

  assign wr_en = alu_valid && !halted_q && (rd_idx != 5'd0);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, so the default copy below is overridden
    // in program order by the single write. State flops use non-blocking assignments only.
    regs_d   = regs_q;
    halted_d = halted_q;
    if (wr_en) begin
      regs_d[rd_idx] = alu_out;
    end
    if (is_ebreak) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this register file is architecturally cleared by reset, so it is built from resettable
      // flops rather than a RAM macro. Plain storage arrays are normally left without a reset.
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      halted_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_rv32_alu_datapath.sv
// Self-checking bench for rv32_alu_datapath. It uses decode vectors, directed program sequences and
// randomized instructions, and checks them against an architectural register model.
`timescale 1ns/1ps
module tb_rv32_alu_datapath;

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_REG = 7'b0110011;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;

  logic clk = 1'b0;
  logic reset;

  rv32_alu_datapath_if bus ();

  rv32_alu_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_regs [32];
  bit          model_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
    return {imm, rs1, f3, rd, OP_IMM};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  // Reference model, computed from the ISA rules on the architectural register array
  function automatic void ref_eval(input logic [31:0] ins, output logic [31:0] res,
                                   output bit legal, output bit ebk);
    logic [31:0] a, b;
    logic [6:0]  f7;
    logic [2:0]  f3;
    f7    = ins[31:25];
    f3    = ins[14:12];
    a     = (ins[19:15] == 0) ? 32'd0 : model_regs[ins[19:15]];
    res   = 32'd0;
    legal = 1'b0;
    ebk   = (ins == EBREAK);
    if (ins[6:0] == OP_IMM) begin
      b     = {{20{ins[31]}}, ins[31:20]};
      legal = 1'b1;
      case (f3)
        3'd0: res = a + b;
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd6: res = a | b;
        3'd7: res = a & b;
        3'd1: begin legal = (f7 == 7'h00); res = a << ins[24:20]; end
        default: begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          res   = (f7 == 7'h20) ? 32'($signed(a) >>> ins[24:20]) : a >> ins[24:20];
        end
      endcase
    end else if (ins[6:0] == OP_REG) begin
      b = (ins[24:20] == 0) ? 32'd0 : model_regs[ins[24:20]];
      if (f7 == 7'h00) begin
        legal = 1'b1;
        case (f3)
          3'd0: res = a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = a >> b[4:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        legal = 1'b1;
        res   = a - b;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        legal = 1'b1;
        res   = 32'($signed(a) >>> b[4:0]);
      end
    end
    if (!legal) res = 32'd0;
  endfunction

  function automatic void model_reset();
    foreach (model_regs[i]) model_regs[i] = 32'd0;
    model_halted = 1'b0;
  endfunction

  // Present one instruction (called at posedge+1), check outputs, commit at the next edge
  task automatic exec(input logic [31:0] ins, input string name);
    logic [31:0] res;
    bit legal, ebk;
    ref_eval(ins, res, legal, ebk);
    bus.instr = ins;
    #1;
    check({name, " result"}, bus.result, res);
    check({name, " illegal"}, {31'd0, bus.illegal}, {31'd0, !legal && !ebk});
    check({name, " ebreak"}, {31'd0, bus.ebreak}, {31'd0, ebk});
    @(posedge clk);
    if (!model_halted) begin
      if (legal && ins[11:7] != 0) model_regs[ins[11:7]] = res;
      if (ebk) model_halted = 1'b1;
    end
    #1;
    check({name, " halted"}, {31'd0, bus.halted}, {31'd0, model_halted});
  endtask

  task automatic check_reg(input int idx, input logic [31:0] exp);
    bus.dbg_addr = 5'(idx);
    #1;
    check($sformatf("x%0d", idx), bus.dbg_data, exp);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 32; i++) check_reg(i, model_regs[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  f7, opc;
    logic [31:0] ins;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 9) == 0)  opc = 7'h73;
    else if ($urandom_range(0, 1)) opc = OP_REG;
    else                            opc = OP_IMM;
    ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           5'($urandom_range(0, 7)), opc};
    if (ins == EBREAK) ins = ECALL;
    return ins;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_result;
    logic        exp_illegal;
    logic        exp_ebreak;
    string       name;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Decode vectors, all evaluated with zeroed registers while reset holds off write-back
    vecs[0]  = '{enc_i(12'd5, 0, 3'd0, 1),       32'h00000005, 1'b0, 1'b0, "addi 5"};
    vecs[1]  = '{enc_i(12'hFF8, 0, 3'd0, 1),     32'hFFFFFFF8, 1'b0, 1'b0, "addi -8"};
    vecs[2]  = '{enc_i(12'd1, 0, 3'd2, 1),       32'h00000001, 1'b0, 1'b0, "slti 1"};
    vecs[3]  = '{enc_i(12'hFFF, 0, 3'd2, 1),     32'h00000000, 1'b0, 1'b0, "slti -1"};
    vecs[4]  = '{enc_i(12'hFFF, 0, 3'd3, 1),     32'h00000001, 1'b0, 1'b0, "sltiu -1"};
    vecs[5]  = '{enc_i(12'h7FF, 0, 3'd4, 1),     32'h000007FF, 1'b0, 1'b0, "xori"};
    vecs[6]  = '{enc_i(12'h800, 0, 3'd6, 1),     32'hFFFFF800, 1'b0, 1'b0, "ori"};
    vecs[7]  = '{enc_i(12'hFFF, 0, 3'd7, 1),     32'h00000000, 1'b0, 1'b0, "andi"};
    vecs[8]  = '{enc_i(12'h021, 0, 3'd1, 1),     32'h00000000, 1'b1, 1'b0, "slli bad f7"};
    vecs[9]  = '{enc_i(12'h403, 0, 3'd5, 1),     32'h00000000, 1'b0, 1'b0, "srai"};
    vecs[10] = '{enc_r(7'h20, 0, 0, 3'd0, 1),    32'h00000000, 1'b0, 1'b0, "sub"};
    vecs[11] = '{enc_r(7'h20, 0, 0, 3'd1, 1),    32'h00000000, 1'b1, 1'b0, "alt sll"};
    vecs[12] = '{enc_r(7'h01, 0, 0, 3'd0, 1),    32'h00000000, 1'b1, 1'b0, "add f7=1"};
    vecs[13] = '{ECALL,                          32'h00000000, 1'b1, 1'b0, "ecall"};
    vecs[14] = '{EBREAK,                         32'h00000000, 1'b0, 1'b1, "ebreak"};
    vecs[15] = '{32'h12345037,                   32'h00000000, 1'b1, 1'b0, "lui"};
    vecs[16] = '{enc_r(7'h00, 0, 0, 3'd3, 1),    32'h00000000, 1'b0, 1'b0, "sltu"};

    reset        = 1'b1;
    bus.instr    = 32'd0;
    bus.dbg_addr = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset halted", {31'd0, bus.halted}, 32'd0);
    for (int i = 0; i < 32; i += 7) check_reg(i, 32'd0);

    for (int i = 0; i < 17; i++) begin
      bus.instr = vecs[i].instr;
      #1;
      check({vecs[i].name, " result"}, bus.result, vecs[i].exp_result);
      check({vecs[i].name, " illegal"}, {31'd0, bus.illegal}, {31'd0, vecs[i].exp_illegal});
      check({vecs[i].name, " ebreak"}, {31'd0, bus.ebreak}, {31'd0, vecs[i].exp_ebreak});
      @(posedge clk);
      #1;
    end
    check("halted under reset", {31'd0, bus.halted}, 32'd0);
    reset = 1'b0;

    // Dependent ADDI chain, SUB, then EBREAK halts further writes
    exec(enc_i(12'd10, 0, 3'd0, 1), "addi x1,x0,10");
    exec(enc_i(12'd40, 1, 3'd0, 1), "addi x1,x1,40");
    exec(enc_i(12'd10, 1, 3'd0, 2), "addi x2,x1,10");
    exec(enc_i(12'd1, 2, 3'd0, 3), "addi x3,x2,1");
    exec(enc_i(12'd1, 3, 3'd0, 4), "addi x4,x3,1");
    exec(enc_r(7'h20, 1, 4, 3'd0, 5), "sub x5,x4,x1");
    exec(EBREAK, "ebreak");
    check("halted after ebreak", {31'd0, bus.halted}, 32'd1);
    exec(enc_i(12'd7, 0, 3'd0, 6), "addi x6 halted");
    check_reg(1, 32'd50);
    check_reg(2, 32'd60);
    check_reg(3, 32'd61);
    check_reg(4, 32'd62);
    check_reg(5, 32'd12);
    check_reg(6, 32'd0);

    // Reset clears a halted core
    do_reset();
    check("halted cleared", {31'd0, bus.halted}, 32'd0);

    // x0 writes are discarded
    exec(enc_i(12'd5, 0, 3'd0, 0), "addi x0,x0,5");
    check("x0 result", bus.result, 32'd5);
    check_reg(0, 32'd0);

    // Arithmetic vs logical right shift
    exec(enc_i(12'hFF8, 0, 3'd0, 1), "addi x1,-8");
    exec(enc_i(12'h401, 1, 3'd5, 2), "srai x2,x1,1");
    exec(enc_i(12'd28, 1, 3'd5, 3), "srli x3,x1,28");
    check_reg(1, 32'hFFFFFFF8);
    check_reg(2, 32'hFFFFFFFC);
    check_reg(3, 32'h0000000F);

    // Signed/unsigned compare and wrapping add
    exec(enc_i(12'hFFF, 0, 3'd0, 1), "addi x1,-1");
    exec(enc_i(12'd0, 1, 3'd2, 4), "slti x4,x1,0");
    exec(enc_i(12'd1, 1, 3'd3, 5), "sltiu x5,x1,1");
    exec(enc_r(7'h00, 1, 1, 3'd0, 6), "add x6,x1,x1");
    check_reg(4, 32'd1);
    check_reg(5, 32'd0);
    check_reg(6, 32'hFFFFFFFE);

    // Illegal encodings leave the architectural state untouched
    exec(enc_r(7'h01, 1, 1, 3'd0, 7), "add f7=1");
    exec(ECALL, "ecall");
    check("halted after illegal", {31'd0, bus.halted}, 32'd0);
    check_all_regs();

    // Reset wins over a simultaneous valid write
    reset     = 1'b1;
    bus.instr = enc_i(12'd3, 0, 3'd0, 7);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("halted after reset", {31'd0, bus.halted}, 32'd0);
    check_reg(1, 32'd0);
    check_reg(6, 32'd0);
    check_reg(7, 32'd0);

    // Randomized instructions against the model
    for (int n = 0; n < 300; n++) begin
      exec(rand_instr(), $sformatf("rand%0d", n));
      if (n % 50 == 49) check_all_regs();
    end
    check_all_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
